// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder, array and drain stage.
//   skew_state_t   : feeder FSM state encoding
//   clog2_min1()   : bit width needed to hold values 0..n-1, never below 1
//   SYSTOLIC_LANE  : lane r slice of a packed vector of dw-bit elements
`ifndef SYSTOLIC_LANE
`define SYSTOLIC_LANE(vec, r, dw) vec[((r)+1)*(dw)-1 -: (dw)]
`endif

package systolic_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} skew_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_act_skewer_if.sv
// Activation input stream of the skewer (valid/ready with end-of-block marker).
//   s_valid : beat valid          (master -> slave)
//   s_ready : beat ready          (slave -> master)
//   s_data  : packed lane vector  (master -> slave), lane r = [(r+1)*DW-1 -: DW]
//   s_last  : last beat of block  (master -> slave)
interface systolic_act_skewer_if #(
    parameter int ARRAY_ROWS = 4,
    parameter int DATA_WIDTH = 8
);
    logic                             s_valid;
    logic                             s_ready;
    logic [ARRAY_ROWS*DATA_WIDTH-1:0] s_data;
    logic                             s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register of {valid, data} for one skew lane.
//   clk, rst  : clock, asynchronous active-high clear
//   en        : advance enable; all stages hold when low
//   in_valid  : valid entering stage 0
//   in_data   : data entering stage 0
//   out_valid : valid leaving the last stage
//   out_data  : data leaving the last stage
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]      vld;
    logic [DATA_WIDTH-1:0] dat [DEPTH];

    // NOTE: the data stages are cleared too, not just valid, so the array
    // never sees leftover data after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments let every stage sample the value
            // its predecessor held before this edge.
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/systolic_act_skewer.sv
// Upstream feeder of the weight-stationary systolic array: applies the
// diagonal skew (lane r delayed r+1 cycles), flushes at end of block and
// reports completion.
//   clk, rst   : clock, asynchronous active-high reset
//   s          : activation input stream (slave side)
//   stall      : downstream hold; freezes the feeder and the array
//   act_out    : skewed activations to the array act_in
//   act_valid  : per-lane valid, skewed like act_out
//   arr_enable : array enable (= !stall)
//   busy       : FSM not idle
//   done       : one-cycle pulse when the flush completes
//   beat_cnt   : beats accepted in the current block, saturating
module systolic_act_skewer
    import systolic_pkg::*;
#(
    parameter int ARRAY_ROWS = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    systolic_act_skewer_if.slave             s,
    input  logic                             stall,
    output logic [ARRAY_ROWS*DATA_WIDTH-1:0] act_out,
    output logic [ARRAY_ROWS-1:0]            act_valid,
    output logic                             arr_enable,
    output logic                             busy,
    output logic                             done,
    output logic [CNT_WIDTH-1:0]             beat_cnt
);

    localparam int FLUSH_W = clog2_min1(ARRAY_ROWS + 1);

    skew_state_t        state, state_next;
    logic [FLUSH_W-1:0] flush_cnt, flush_next;
    logic               advance;
    logic               accept;

    assign advance    = !stall;
    assign arr_enable = advance;
    assign s.s_ready  = advance && (state != FLUSH);
    assign accept     = s.s_valid && s.s_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_next;
        end
    end

    // flush_cnt counts the flush cycles still to go, including the current
    // one; done fires on the last of them, which is the cycle the deepest
    // lane presents the final beat.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        flush_next = flush_cnt;
        done       = 1'b0;
        if (advance) begin
            unique case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (s.s_last) begin
                            state_next = FLUSH;
                            flush_next = FLUSH_W'(ARRAY_ROWS);
                        end else begin
                            state_next = STREAM;
                        end
                    end
                end
                FLUSH: begin
                    flush_next = flush_cnt - FLUSH_W'(1);
                    if (flush_cnt == FLUSH_W'(1)) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // First accept of a block loads 1; later accepts saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept) begin
            if (state == IDLE)      beat_cnt <= CNT_WIDTH'(1);
            else if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        end
    end

    // Non-accept cycles push zero data with valid low, so the array sees
    // clean bubbles rather than stale activations.
    for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in;

        assign lane_in = accept ? `SYSTOLIC_LANE(s.s_data, r, DATA_WIDTH) : '0;

        skew_delay_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_delay (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (accept),
            .in_data   (lane_in),
            .out_valid (act_valid[r]),
            .out_data  (`SYSTOLIC_LANE(act_out, r, DATA_WIDTH))
        );
    end

endmodule

// File: tb/tb_systolic_act_skewer.sv
// Self-checking bench for systolic_act_skewer (ARRAY_ROWS=4, DATA_WIDTH=8).
// A history queue of accepted beats is pushed on every advancing edge and
// popped as entries leave the deepest lane; lane r expects the entry pushed
// r+1 advances ago.
module tb_systolic_act_skewer;

    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [ROWS*DW-1:0] act_out;
    logic [ROWS-1:0] act_valid;
    logic            arr_enable, busy, done;
    logic [CW-1:0]   beat_cnt;

    systolic_act_skewer_if #(.ARRAY_ROWS(ROWS), .DATA_WIDTH(DW)) s_if ();

    systolic_act_skewer #(.ARRAY_ROWS(ROWS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s_if),
        .stall      (stall),
        .act_out    (act_out),
        .act_valid  (act_valid),
        .arr_enable (arr_enable),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int d_seen = 0;
    int ready_low = 0;

    // reference model: 0 idle, 1 streaming, 2 flushing
    int          m_state;
    int          m_fcyc;
    logic [15:0] m_beat;
    logic [32:0] hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < ROWS; i++) hist.push_back('0);
        m_state = 0;
        m_fcyc  = 0;
        m_beat  = '0;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic st, input bit chk);
        logic        acc;
        logic        exp_ready, exp_done;
        logic [31:0] exp_data;
        logic [3:0]  exp_vld;
        logic [32:0] e;
        @(negedge clk);
        s_if.s_valid = v;
        s_if.s_data  = d;
        s_if.s_last  = l;
        stall        = st;
        #1;
        exp_ready = !st && (m_state != 2);
        exp_done  = (m_state == 2) && !st && (m_fcyc == ROWS - 1);
        for (int r = 0; r < ROWS; r++) begin
            e = hist[ROWS-1-r];
            exp_data[r*DW +: DW] = e[r*DW +: DW];
            exp_vld[r] = e[32];
        end
        if (chk) begin
            check("act_out",    act_out,    exp_data);
            check("act_valid",  {28'h0, act_valid}, {28'h0, exp_vld});
            check("s_ready",    {31'h0, s_if.s_ready}, {31'h0, exp_ready});
            check("arr_enable", {31'h0, arr_enable}, {31'h0, !st});
            check("busy",       {31'h0, busy}, {31'h0, m_state != 0});
            check("done",       {31'h0, done}, {31'h0, exp_done});
            check("beat_cnt",   {16'h0, beat_cnt}, {16'h0, m_beat});
        end
        if (done === 1'b1) d_seen++;
        if (s_if.s_ready === 1'b0) ready_low++;
        acc = v && exp_ready;
        @(posedge clk);
        if (!st) begin
            void'(hist.pop_front());
            hist.push_back({acc, acc ? d : 32'h0});
            case (m_state)
                0, 1: if (acc) begin
                    if (m_state == 0) m_beat = 16'd1;
                    else if (m_beat != 16'hFFFF) m_beat = m_beat + 16'd1;
                    if (l) begin m_state = 2; m_fcyc = 0; end
                    else m_state = 1;
                end
                default: if (m_fcyc == ROWS - 1) m_state = 0; else m_fcyc++;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        s_if.s_last  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_act_out",   act_out, 32'h0);
        check("rst_act_valid", {28'h0, act_valid}, 32'h0);
        check("rst_busy",      {31'h0, busy}, 32'h0);
        check("rst_done",      {31'h0, done}, 32'h0);
        check("rst_beat_cnt",  {16'h0, beat_cnt}, 32'h0);
        check("rst_arr_enable",{31'h0, arr_enable}, 32'h1);
        rst = 1'b0;

        // 1: single-beat block
        d_seen = 0;
        step(1'b1, 32'h04030201, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("t1_done_pulses", d_seen, 1);
        check("t1_beat_cnt", {16'h0, beat_cnt}, 32'd1);

        // 2: three back-to-back beats
        d_seen = 0;
        step(1'b1, 32'h04030201, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h14131211, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h24232221, 1'b1, 1'b0, 1'b1);
        ready_low = 0;
        idle(6);
        check("t2_ready_low_cycles", ready_low, 4);
        check("t2_done_pulses", d_seen, 1);
        check("t2_beat_cnt", {16'h0, beat_cnt}, 32'd3);

        // 3: two stalled cycles mid-stream
        d_seen = 0;
        step(1'b1, 32'h34333231, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h44434241, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h54535251, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h54535251, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'h54535251, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        idle(6);
        check("t3_done_pulses", d_seen, 1);
        check("t3_beat_cnt", {16'h0, beat_cnt}, 32'd3);

        // 4: one-cycle gap between beats
        d_seen = 0;
        step(1'b1, 32'h64636261, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h74737271, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("t4_done_pulses", d_seen, 1);

        // 5: asynchronous reset during flush
        d_seen = 0;
        step(1'b1, 32'h84838281, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h94939291, 1'b1, 1'b0, 1'b1);
        idle(2);
        @(negedge clk);
        s_if.s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_act_out",   act_out, 32'h0);
        check("t5_act_valid", {28'h0, act_valid}, 32'h0);
        check("t5_busy",      {31'h0, busy}, 32'h0);
        check("t5_done",      {31'h0, done}, 32'h0);
        check("t5_beat_cnt",  {16'h0, beat_cnt}, 32'h0);
        model_reset();
        #1 rst = 1'b0;
        idle(2);
        check("t5_done_pulses", d_seen, 0);
        step(1'b1, 32'h04030201, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("t5_rerun_done_pulses", d_seen, 1);

        // 6: beat counter saturation
        for (int i = 0; i < 70000; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        #1;
        check("t6_beat_cnt_sat", {16'h0, beat_cnt}, 32'h0000FFFF);
        step(1'b1, 32'hA4A3A2A1, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("t6_beat_cnt_final", {16'h0, beat_cnt}, 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
